// File: rtl/hash_table_pkg.sv
// Shared hash-table types: command opcodes, the command record and the
// hazard-guard holding-register states.
package hash_table_pkg;

  localparam int HT_KEY_WIDTH    = 32;
  localparam int HT_VALUE_WIDTH  = 16;
  localparam int HT_BUCKET_WIDTH = 8;
  localparam int HT_MAX_INFLIGHT = 4;

  typedef enum logic [1:0] {
    OP_SEARCH = 2'd0,
    OP_INSERT = 2'd1,
    OP_DELETE = 2'd2
  } ht_opcode_t;

  typedef struct packed {
    ht_opcode_t                 opcode;
    logic [HT_KEY_WIDTH-1:0]    key;
    logic [HT_VALUE_WIDTH-1:0]  value;
    logic [HT_BUCKET_WIDTH-1:0] bucket;
  } ht_command_t;

  typedef enum logic [1:0] {
    HOLD_EMPTY   = 2'd0,
    HOLD_BLOCKED = 2'd1,
    HOLD_READY   = 2'd2
  } hold_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/ht_cmd_hazard_guard_inflight_table.sv
// Table of buckets currently owned by the bucket engine. Entries are
// allocated lowest-free-first on issue and cleared by bucket on completion.
module ht_inflight_table #(
  parameter int BUCKET_WIDTH = 8,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              alloc_i,
  input  logic [BUCKET_WIDTH-1:0]           alloc_bucket_i,
  input  logic                              free_i,
  input  logic [BUCKET_WIDTH-1:0]           free_bucket_i,
  input  logic [BUCKET_WIDTH-1:0]           lookup_bucket_i,
  output logic                              hit_o,
  output logic                              full_o,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] cnt_o,
  output logic                              miss_err_o
);

  localparam int IDX_W = $clog2(MAX_INFLIGHT);
  localparam int CNT_W = $clog2(MAX_INFLIGHT+1);

  logic [MAX_INFLIGHT-1:0] r_valid;
  logic [BUCKET_WIDTH-1:0] r_bucket [MAX_INFLIGHT];

  logic [MAX_INFLIGHT-1:0] w_lookup_vec;
  logic [MAX_INFLIGHT-1:0] w_free_vec;
  logic [IDX_W-1:0]        w_alloc_idx;
  logic [CNT_W-1:0]        w_cnt;
  logic                    w_alloc;

  // NOTE: every always_comb output gets a default first so no path can leave it unassigned (no latch).
  always_comb begin
    w_lookup_vec = '0;
    w_free_vec   = '0;
    w_alloc_idx  = '0;
    w_cnt        = '0;
    for (int i = MAX_INFLIGHT-1; i >= 0; i--) begin
      w_lookup_vec[i] = r_valid[i] && (r_bucket[i] == lookup_bucket_i);
      w_free_vec[i]   = r_valid[i] && (r_bucket[i] == free_bucket_i);
      w_cnt           = w_cnt + CNT_W'(r_valid[i]);
      if (!r_valid[i]) w_alloc_idx = IDX_W'(i);
    end
  end

  assign full_o     = &r_valid;
  assign hit_o      = |w_lookup_vec;
  assign cnt_o      = w_cnt;
  assign miss_err_o = free_i && !(|w_free_vec);
  assign w_alloc    = alloc_i && !full_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid <= '0;
    end else begin
      for (int i = 0; i < MAX_INFLIGHT; i++) begin
        if (free_i && w_free_vec[i]) r_valid[i] <= 1'b0;
      end
      if (w_alloc) r_valid[w_alloc_idx] <= 1'b1;
    end
  end

  // NOTE: bucket storage is not reset; it is only ever read through its valid bit.
  always_ff @(posedge clk_i) begin
    if (w_alloc) r_bucket[w_alloc_idx] <= alloc_bucket_i;
  end

endmodule

// File: rtl/ht_cmd_hazard_guard.sv
// Per-bucket ordering guard: holds one command until its bucket is no longer
// in flight in the bucket engine and the in-flight table has room.
module ht_cmd_hazard_guard
  import hash_table_pkg::*;
#(
  parameter int KEY_WIDTH    = HT_KEY_WIDTH,
  parameter int VALUE_WIDTH  = HT_VALUE_WIDTH,
  parameter int BUCKET_WIDTH = HT_BUCKET_WIDTH,
  parameter int MAX_INFLIGHT = HT_MAX_INFLIGHT
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              in_valid_i,
  output logic                              in_ready_o,
  input  ht_opcode_t                        in_opcode_i,
  input  logic [KEY_WIDTH-1:0]              in_key_i,
  input  logic [VALUE_WIDTH-1:0]            in_value_i,
  input  logic [BUCKET_WIDTH-1:0]           in_bucket_i,
  output logic                              out_valid_o,
  input  logic                              out_ready_i,
  output ht_opcode_t                        out_opcode_o,
  output logic [KEY_WIDTH-1:0]              out_key_o,
  output logic [VALUE_WIDTH-1:0]            out_value_o,
  output logic [BUCKET_WIDTH-1:0]           out_bucket_o,
  input  logic                              done_valid_i,
  input  logic [BUCKET_WIDTH-1:0]           done_bucket_i,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight_cnt_o,
  output logic [15:0]                       stall_cnt_o,
  output logic                              err_o
);

  logic                    r_held;
  ht_opcode_t              r_opcode;
  logic [KEY_WIDTH-1:0]    r_key;
  logic [VALUE_WIDTH-1:0]  r_value;
  logic [BUCKET_WIDTH-1:0] r_bucket;
  logic [15:0]             r_stall_cnt;
  logic                    r_err;

  logic        w_hit;
  logic        w_full;
  logic        w_miss_err;
  logic        w_issue;
  logic        w_accept;
  hold_state_t w_state;

  // Ready/blocked is re-derived every cycle from the registered table, so a
  // completion frees the held command exactly one cycle later.
  always_comb begin
    w_state = HOLD_EMPTY;
    if (r_held) w_state = (w_hit || w_full) ? HOLD_BLOCKED : HOLD_READY;
  end

  assign out_valid_o = (w_state == HOLD_READY);
  assign w_issue     = out_valid_o && out_ready_i;
  assign in_ready_o  = (w_state == HOLD_EMPTY) || w_issue;
  assign w_accept    = in_valid_i && in_ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_held      <= 1'b0;
      r_opcode    <= OP_SEARCH;
      r_key       <= '0;
      r_value     <= '0;
      r_bucket    <= '0;
      r_stall_cnt <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_accept) begin
        r_held   <= 1'b1;
        r_opcode <= in_opcode_i;
        r_key    <= in_key_i;
        r_value  <= in_value_i;
        r_bucket <= in_bucket_i;
      end else if (w_issue) begin
        r_held <= 1'b0;
      end
      if (w_state == HOLD_BLOCKED) r_stall_cnt <= sat_inc16(r_stall_cnt);
      if (w_miss_err) r_err <= 1'b1;
    end
  end

  assign out_opcode_o = r_opcode;
  assign out_key_o    = r_key;
  assign out_value_o  = r_value;
  assign out_bucket_o = r_bucket;
  assign stall_cnt_o  = r_stall_cnt;
  assign err_o        = r_err;

  ht_inflight_table #(
    .BUCKET_WIDTH (BUCKET_WIDTH),
    .MAX_INFLIGHT (MAX_INFLIGHT)
  ) u_table (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .alloc_i         (w_issue),
    .alloc_bucket_i  (r_bucket),
    .free_i          (done_valid_i),
    .free_bucket_i   (done_bucket_i),
    .lookup_bucket_i (r_bucket),
    .hit_o           (w_hit),
    .full_o          (w_full),
    .cnt_o           (inflight_cnt_o),
    .miss_err_o      (w_miss_err)
  );

endmodule

// File: tb/tb_ht_cmd_hazard_guard.sv
// Bench for ht_cmd_hazard_guard: directed scenarios plus a randomized run
// against a queue-based model of per-bucket ordering.
module tb_ht_cmd_hazard_guard;
  import hash_table_pkg::*;

  localparam int KW = 32;
  localparam int VW = 16;
  localparam int BW = 8;
  localparam int MI = 4;
  localparam int CW = $clog2(MI+1);

  logic          clk_i;
  logic          rst_i;
  logic          in_valid_i;
  logic          in_ready_o;
  ht_opcode_t    in_opcode_i;
  logic [KW-1:0] in_key_i;
  logic [VW-1:0] in_value_i;
  logic [BW-1:0] in_bucket_i;
  logic          out_valid_o;
  logic          out_ready_i;
  ht_opcode_t    out_opcode_o;
  logic [KW-1:0] out_key_o;
  logic [VW-1:0] out_value_o;
  logic [BW-1:0] out_bucket_o;
  logic          done_valid_i;
  logic [BW-1:0] done_bucket_i;
  logic [CW-1:0] inflight_cnt_o;
  logic [15:0]   stall_cnt_o;
  logic          err_o;

  int n_pass  = 0;
  int n_total = 0;

  ht_cmd_hazard_guard #(
    .KEY_WIDTH    (KW),
    .VALUE_WIDTH  (VW),
    .BUCKET_WIDTH (BW),
    .MAX_INFLIGHT (MI)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .in_valid_i     (in_valid_i),
    .in_ready_o     (in_ready_o),
    .in_opcode_i    (in_opcode_i),
    .in_key_i       (in_key_i),
    .in_value_i     (in_value_i),
    .in_bucket_i    (in_bucket_i),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .out_opcode_o   (out_opcode_o),
    .out_key_o      (out_key_o),
    .out_value_o    (out_value_o),
    .out_bucket_o   (out_bucket_o),
    .done_valid_i   (done_valid_i),
    .done_bucket_i  (done_bucket_i),
    .inflight_cnt_o (inflight_cnt_o),
    .stall_cnt_o    (stall_cnt_o),
    .err_o          (err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  task automatic set_idle();
    in_valid_i    = 1'b0;
    in_opcode_i   = OP_SEARCH;
    in_key_i      = '0;
    in_value_i    = '0;
    in_bucket_i   = '0;
    out_ready_i   = 1'b0;
    done_valid_i  = 1'b0;
    done_bucket_i = '0;
  endtask

  task automatic send(input ht_opcode_t op, input logic [KW-1:0] k,
                      input logic [VW-1:0] v, input logic [BW-1:0] b);
    in_valid_i  = 1'b1;
    in_opcode_i = op;
    in_key_i    = k;
    in_value_i  = v;
    in_bucket_i = b;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    set_idle();
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  // Four distinct buckets issued, then the given bucket left pending on a full table.
  task automatic fill(input logic [BW-1:0] pend);
    bit reached;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      out_ready_i = 1'b1;
      if (i < 4) send(OP_INSERT, KW'(32'h2000 + i), VW'(i), BW'(i + 1));
      else       send(OP_SEARCH, 32'h9999_0000, 16'h0, pend);
    end
    reached = 1'b0;
    for (int w = 0; w < 10 && !reached; w++) begin
      @(negedge clk_i);
      in_valid_i = 1'b0;
      #1;
      if (inflight_cnt_o == CW'(MI)) reached = 1'b1;
    end
    n_total++;
    if (!reached) $display("FAIL fill_timeout: inflight=%0d required=%0d", inflight_cnt_o, MI);
    else n_pass++;
  endtask

  task automatic test_reset();
    @(negedge clk_i);
    set_idle();
    rst_i = 1'b1;
    @(negedge clk_i);
    #1;
    n_total++; if (in_ready_o !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", in_ready_o); else n_pass++;
    n_total++; if (out_valid_o !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid_o); else n_pass++;
    n_total++;
    if ({out_opcode_o, out_key_o, out_value_o, out_bucket_o} !== '0)
      $display("FAIL rst_out_fields: got op=%0d key=%h val=%h bkt=%h want all 0", out_opcode_o, out_key_o, out_value_o, out_bucket_o);
    else n_pass++;
    n_total++; if (inflight_cnt_o !== CW'(0)) $display("FAIL rst_inflight: got %0d want 0", inflight_cnt_o); else n_pass++;
    n_total++; if (stall_cnt_o !== 16'd0) $display("FAIL rst_stall: got %0d want 0", stall_cnt_o); else n_pass++;
    n_total++; if (err_o !== 1'b0) $display("FAIL rst_err: got %b want 0", err_o); else n_pass++;
    rst_i = 1'b0;
  endtask

  task automatic test_throughput();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      out_ready_i = 1'b1;
      send(OP_INSERT, KW'(32'h1000 + i), VW'(i), BW'(i + 1));
      #1;
      n_total++; if (in_ready_o !== 1'b1) $display("FAIL thr_in_ready c%0d: got %b want 1", i, in_ready_o); else n_pass++;
      n_total++; if (out_valid_o !== (i > 0)) $display("FAIL thr_out_valid c%0d: got %b want %b", i, out_valid_o, (i > 0)); else n_pass++;
      if (i > 0) begin
        n_total++; if (out_bucket_o !== BW'(i)) $display("FAIL thr_bucket c%0d: got %0d want %0d", i, out_bucket_o, i); else n_pass++;
      end
      n_total++;
      if (inflight_cnt_o !== CW'((i > 0) ? i - 1 : 0)) $display("FAIL thr_inflight c%0d: got %0d want %0d", i, inflight_cnt_o, (i > 0) ? i - 1 : 0);
      else n_pass++;
    end
    for (int j = 0; j < 4; j++) begin
      @(negedge clk_i);
      in_valid_i = 1'b0;
      #1;
      n_total++; if (out_valid_o !== 1'b0) $display("FAIL thr5_out_valid +%0d: got %b want 0", j, out_valid_o); else n_pass++;
      n_total++; if (in_ready_o !== 1'b0) $display("FAIL thr5_in_ready +%0d: got %b want 0", j, in_ready_o); else n_pass++;
      n_total++; if (inflight_cnt_o !== CW'(4)) $display("FAIL thr5_inflight +%0d: got %0d want 4", j, inflight_cnt_o); else n_pass++;
      n_total++; if (stall_cnt_o !== 16'(j)) $display("FAIL thr5_stall +%0d: got %0d want %0d", j, stall_cnt_o, j); else n_pass++;
    end
  endtask

  task automatic test_full_done();
    fill(8'd9);
    @(negedge clk_i);
    done_valid_i  = 1'b1;
    done_bucket_i = 8'd2;
    out_ready_i   = 1'b1;
    #1;
    n_total++; if (out_valid_o !== 1'b0) $display("FAIL full_done_bypass: got %b want 0", out_valid_o); else n_pass++;
    @(negedge clk_i);
    done_valid_i = 1'b0;
    #1;
    n_total++; if (out_valid_o !== 1'b1) $display("FAIL full_done_valid: got %b want 1", out_valid_o); else n_pass++;
    n_total++; if (out_bucket_o !== 8'd9) $display("FAIL full_done_bucket: got %0d want 9", out_bucket_o); else n_pass++;
    n_total++; if (inflight_cnt_o !== CW'(3)) $display("FAIL full_done_cnt3: got %0d want 3", inflight_cnt_o); else n_pass++;
    @(negedge clk_i);
    #1;
    n_total++; if (inflight_cnt_o !== CW'(4)) $display("FAIL full_done_cnt4: got %0d want 4", inflight_cnt_o); else n_pass++;
    n_total++; if (out_valid_o !== 1'b0) $display("FAIL full_done_after: got %b want 0", out_valid_o); else n_pass++;
  endtask

  task automatic test_hazard();
    do_reset();
    @(negedge clk_i);
    out_ready_i = 1'b1;
    send(OP_INSERT, 32'hAAAA_0007, 16'h1234, 8'd7);
    @(negedge clk_i);
    send(OP_SEARCH, 32'hBBBB_0007, 16'h0000, 8'd7);
    #1;
    n_total++; if (out_valid_o !== 1'b1 || out_opcode_o !== OP_INSERT) $display("FAIL haz_insert: got v=%b op=%0d want v=1 op=%0d", out_valid_o, out_opcode_o, OP_INSERT); else n_pass++;
    @(negedge clk_i);
    in_valid_i = 1'b0;
    #1;
    n_total++; if (out_valid_o !== 1'b0) $display("FAIL haz_blocked: got %b want 0", out_valid_o); else n_pass++;
    n_total++; if (inflight_cnt_o !== CW'(1)) $display("FAIL haz_inflight: got %0d want 1", inflight_cnt_o); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      #1;
      n_total++; if (out_valid_o !== 1'b0) $display("FAIL haz_hold +%0d: got %b want 0", k, out_valid_o); else n_pass++;
      n_total++; if (stall_cnt_o !== 16'(k + 1)) $display("FAIL haz_stall +%0d: got %0d want %0d", k, stall_cnt_o, k + 1); else n_pass++;
    end
    @(negedge clk_i);
    done_valid_i  = 1'b1;
    done_bucket_i = 8'd7;
    #1;
    n_total++; if (out_valid_o !== 1'b0) $display("FAIL haz_done_cycle: got %b want 0", out_valid_o); else n_pass++;
    @(negedge clk_i);
    done_valid_i = 1'b0;
    #1;
    n_total++; if (out_valid_o !== 1'b1) $display("FAIL haz_release: got %b want 1", out_valid_o); else n_pass++;
    n_total++;
    if (out_opcode_o !== OP_SEARCH || out_key_o !== 32'hBBBB_0007 || out_bucket_o !== 8'd7)
      $display("FAIL haz_fields: got op=%0d key=%h bkt=%0d want op=%0d key=bbbb0007 bkt=7", out_opcode_o, out_key_o, out_bucket_o, OP_SEARCH);
    else n_pass++;
    n_total++; if (inflight_cnt_o !== CW'(0)) $display("FAIL haz_freed: got %0d want 0", inflight_cnt_o); else n_pass++;
    n_total++; if (stall_cnt_o !== 16'd5) $display("FAIL haz_stall_total: got %0d want 5", stall_cnt_o); else n_pass++;
  endtask

  task automatic test_backpressure();
    do_reset();
    @(negedge clk_i);
    out_ready_i = 1'b0;
    send(OP_DELETE, 32'hCAFE_F00D, 16'h5A5A, 8'd3);
    @(negedge clk_i);
    send(OP_INSERT, 32'h0BAD_0BAD, 16'h0001, 8'd4);
    for (int k = 0; k < 5; k++) begin
      #1;
      n_total++; if (out_valid_o !== 1'b1) $display("FAIL bp_valid +%0d: got %b want 1", k, out_valid_o); else n_pass++;
      n_total++;
      if ({out_opcode_o, out_key_o, out_value_o, out_bucket_o} !== {OP_DELETE, 32'hCAFE_F00D, 16'h5A5A, 8'd3})
        $display("FAIL bp_fields +%0d: got op=%0d key=%h val=%h bkt=%0d want op=%0d key=cafef00d val=5a5a bkt=3",
                 k, out_opcode_o, out_key_o, out_value_o, out_bucket_o, OP_DELETE);
      else n_pass++;
      n_total++; if (in_ready_o !== 1'b0) $display("FAIL bp_in_ready +%0d: got %b want 0", k, in_ready_o); else n_pass++;
      @(negedge clk_i);
    end
    out_ready_i = 1'b1;
    #1;
    n_total++; if (in_ready_o !== 1'b1) $display("FAIL bp_issue_ready: got %b want 1", in_ready_o); else n_pass++;
    @(negedge clk_i);
    out_ready_i = 1'b0;
    in_valid_i  = 1'b0;
    #1;
    n_total++;
    if (out_valid_o !== 1'b1 || out_key_o !== 32'h0BAD_0BAD || out_bucket_o !== 8'd4)
      $display("FAIL bp_next: got v=%b key=%h bkt=%0d want v=1 key=0bad0bad bkt=4", out_valid_o, out_key_o, out_bucket_o);
    else n_pass++;
    n_total++; if (inflight_cnt_o !== CW'(1)) $display("FAIL bp_inflight: got %0d want 1", inflight_cnt_o); else n_pass++;
  endtask

  task automatic test_err();
    do_reset();
    @(negedge clk_i);
    done_valid_i  = 1'b1;
    done_bucket_i = 8'h55;
    #1;
    n_total++; if (err_o !== 1'b0) $display("FAIL err_before: got %b want 0", err_o); else n_pass++;
    @(negedge clk_i);
    done_valid_i = 1'b0;
    #1;
    n_total++; if (err_o !== 1'b1) $display("FAIL err_set: got %b want 1", err_o); else n_pass++;
    n_total++; if (inflight_cnt_o !== CW'(0)) $display("FAIL err_inflight: got %0d want 0", inflight_cnt_o); else n_pass++;
    repeat (3) @(negedge clk_i);
    #1;
    n_total++; if (err_o !== 1'b1) $display("FAIL err_sticky: got %b want 1", err_o); else n_pass++;
    n_total++; if (in_ready_o !== 1'b1) $display("FAIL err_in_ready: got %b want 1", in_ready_o); else n_pass++;
  endtask

  task automatic test_reset_midop();
    logic [BW-1:0] seq [4];
    seq = '{8'd1, 8'd2, 8'd3, 8'd2};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      out_ready_i = 1'b1;
      send(OP_INSERT, KW'(32'h3000 + i), VW'(i), seq[i]);
    end
    @(negedge clk_i);
    in_valid_i = 1'b0;
    #1;
    n_total++; if (inflight_cnt_o !== CW'(3)) $display("FAIL mid_inflight: got %0d want 3", inflight_cnt_o); else n_pass++;
    n_total++; if (out_valid_o !== 1'b0) $display("FAIL mid_blocked: got %b want 0", out_valid_o); else n_pass++;
    @(negedge clk_i);
    #1;
    n_total++; if (stall_cnt_o !== 16'd1) $display("FAIL mid_stall: got %0d want 1", stall_cnt_o); else n_pass++;
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    #1;
    n_total++; if (inflight_cnt_o !== CW'(0)) $display("FAIL mid_rst_inflight: got %0d want 0", inflight_cnt_o); else n_pass++;
    n_total++; if (out_valid_o !== 1'b0) $display("FAIL mid_rst_valid: got %b want 0", out_valid_o); else n_pass++;
    n_total++; if (in_ready_o !== 1'b1) $display("FAIL mid_rst_ready: got %b want 1", in_ready_o); else n_pass++;
    n_total++; if (stall_cnt_o !== 16'd0) $display("FAIL mid_rst_stall: got %0d want 0", stall_cnt_o); else n_pass++;
    rst_i = 1'b0;
  endtask

  // Model: the engine owns a set of buckets; one command may wait in the guard.
  task automatic test_random();
    int          owned [$];
    bit          m_held;
    ht_command_t m_cmd;
    int          m_stall;
    bit          m_err;
    bit          hazard, exp_ov, exp_ir, issue;
    int          found;
    do_reset();
    m_held  = 1'b0;
    m_cmd   = '0;
    m_stall = 0;
    m_err   = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk_i);
      in_valid_i  = ($urandom_range(0, 9) < 7);
      in_opcode_i = ht_opcode_t'($urandom_range(0, 2));
      in_key_i    = $urandom;
      in_value_i  = VW'($urandom);
      in_bucket_i = BW'($urandom_range(0, 5));
      out_ready_i = ($urandom_range(0, 9) < 7);
      if (owned.size() > 0 && $urandom_range(0, 9) < 4) begin
        done_valid_i  = 1'b1;
        done_bucket_i = BW'(owned[$urandom_range(0, owned.size() - 1)]);
      end else begin
        done_valid_i  = 1'b0;
        done_bucket_i = BW'($urandom);
      end
      #1;
      hazard = 1'b0;
      foreach (owned[i]) if (m_held && owned[i] == int'(m_cmd.bucket)) hazard = 1'b1;
      exp_ov = m_held && !hazard && (owned.size() < MI);
      issue  = exp_ov && out_ready_i;
      exp_ir = !m_held || issue;
      n_total++; if (out_valid_o !== exp_ov) $display("FAIL rnd_out_valid c%0d: got %b want %b", c, out_valid_o, exp_ov); else n_pass++;
      n_total++; if (in_ready_o !== exp_ir) $display("FAIL rnd_in_ready c%0d: got %b want %b", c, in_ready_o, exp_ir); else n_pass++;
      if (exp_ov) begin
        n_total++;
        if ({out_opcode_o, out_key_o, out_value_o, out_bucket_o} !== m_cmd)
          $display("FAIL rnd_fields c%0d: got %h want %h", c, {out_opcode_o, out_key_o, out_value_o, out_bucket_o}, m_cmd);
        else n_pass++;
      end
      n_total++; if (inflight_cnt_o !== CW'(owned.size())) $display("FAIL rnd_inflight c%0d: got %0d want %0d", c, inflight_cnt_o, owned.size()); else n_pass++;
      n_total++; if (stall_cnt_o !== 16'(m_stall)) $display("FAIL rnd_stall c%0d: got %0d want %0d", c, stall_cnt_o, m_stall); else n_pass++;
      n_total++; if (err_o !== m_err) $display("FAIL rnd_err c%0d: got %b want %b", c, err_o, m_err); else n_pass++;
      if (done_valid_i) begin
        found = -1;
        foreach (owned[i]) if (owned[i] == int'(done_bucket_i)) found = i;
        if (found >= 0) owned.delete(found);
        else m_err = 1'b1;
      end
      if (issue) owned.push_back(int'(m_cmd.bucket));
      if (m_held && !exp_ov && m_stall < 65535) m_stall++;
      if (in_valid_i && exp_ir) begin
        m_held = 1'b1;
        m_cmd  = '{opcode: in_opcode_i, key: in_key_i, value: in_value_i, bucket: in_bucket_i};
      end else if (issue) begin
        m_held = 1'b0;
      end
    end
  endtask

  initial begin
    set_idle();
    rst_i = 1'b1;
    test_reset();
    test_throughput();
    test_full_done();
    test_hazard();
    test_backpressure();
    test_err();
    test_reset_midop();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
